// File: rtl/mem_loader_pkg.sv
// Shared definitions for the boot-stream SRAM loader: widths, state encodings,
// write-phase length and the SRAM write payload.
package mem_loader_pkg;

  localparam int unsigned STATE_W      = 4;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned WRITE_PHASES = 3;

  localparam logic [STATE_W-1:0] ST_ADDR_H  = STATE_W'(0);
  localparam logic [STATE_W-1:0] ST_ADDR_L  = STATE_W'(1);
  localparam logic [STATE_W-1:0] ST_CNT_H   = STATE_W'(2);
  localparam logic [STATE_W-1:0] ST_CNT_L   = STATE_W'(3);
  localparam logic [STATE_W-1:0] ST_DATA_H  = STATE_W'(4);
  localparam logic [STATE_W-1:0] ST_DATA_L  = STATE_W'(5);
  localparam logic [STATE_W-1:0] ST_W_SETUP = STATE_W'(6);
  localparam logic [STATE_W-1:0] ST_W_PULSE = STATE_W'(7);
  localparam logic [STATE_W-1:0] ST_W_HOLD  = STATE_W'(8);
  localparam logic [STATE_W-1:0] ST_CHK     = STATE_W'(9);
  localparam logic [STATE_W-1:0] ST_DONE    = STATE_W'(10);
  localparam logic [STATE_W-1:0] ST_ERR     = STATE_W'(11);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sram_wr_t;

  // States in which a stream byte may be accepted.
  function automatic logic is_rx_state(input logic [STATE_W-1:0] s);
    return (s == ST_ADDR_H) || (s == ST_ADDR_L) || (s == ST_CNT_H) ||
           (s == ST_CNT_L)  || (s == ST_DATA_H) || (s == ST_DATA_L) ||
           (s == ST_CHK);
  endfunction

  // States in which the loader owns the SRAM bus.
  function automatic logic is_wr_state(input logic [STATE_W-1:0] s);
    return (s == ST_W_SETUP) || (s == ST_W_PULSE) || (s == ST_W_HOLD);
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream input, SRAM bus and CPU-release status of the loader, bundled.
interface mem_loader_if;
  import mem_loader_pkg::*;

  logic [BYTE_W-1:0] rxData;
  logic              rxValid;
  logic              rxReady;
  logic [ADDR_W-1:0] addrOut;
  logic [DATA_W-1:0] dataOut;
  logic              notBusOE;
  logic              memNotCS;
  logic              memNotWE;
  logic              memNotOE;
  logic              cpuNotReset;
  logic              done;
  logic              error;

  // master: the loader itself; slave: stream source, SRAM and CPU side.
  modport master (
    input  rxData, rxValid,
    output rxReady, addrOut, dataOut, notBusOE, memNotCS, memNotWE,
           memNotOE, cpuNotReset, done, error
  );

  modport slave (
    output rxData, rxValid,
    input  rxReady, addrOut, dataOut, notBusOE, memNotCS, memNotWE,
           memNotOE, cpuNotReset, done, error
  );

endinterface

// File: rtl/mem_loader_cksum.sv
// Running modulo-256 sum of accepted stream bytes, with synchronous clear.
module mem_loader_cksum
  import mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [BYTE_W-1:0] sum_o
);

  logic [BYTE_W-1:0] sum_q;
  logic [BYTE_W-1:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = BYTE_W'(sum_q + byte_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/mem_loader.sv
// Boot loader: parses address/count/words/checksum from a byte stream, writes
// each word to SRAM with a 3-cycle strobe, and releases the CPU on a good image.
module mem_loader
  import mem_loader_pkg::*;
(
  input  logic         clock,
  input  logic         notReset,
  mem_loader_if.master bus
);

  logic [STATE_W-1:0] state_q, state_d;
  sram_wr_t           wr_q, wr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic rx_ready_q,  rx_ready_d;
  logic bus_oe_n_q,  bus_oe_n_d;
  logic cs_n_q,      cs_n_d;
  logic we_n_q,      we_n_d;
  logic cpu_rst_n_q, cpu_rst_n_d;
  logic done_q,      done_d;
  logic error_q,     error_d;

  logic              xfer;
  logic              sum_en;
  logic              sum_clr;
  logic [BYTE_W-1:0] sum;

  assign xfer    = bus.rxValid && rx_ready_q;
  // The checksum byte itself is compared, never accumulated.
  assign sum_en  = xfer && (state_q != ST_CHK);
  assign sum_clr = (state_q == ST_DONE) || (state_q == ST_ERR);

  mem_loader_cksum u_cksum (
    .clk    (clock),
    .rst_n  (notReset),
    .clr_i  (sum_clr),
    .en_i   (sum_en),
    .byte_i (bus.rxData),
    .sum_o  (sum)
  );

  // Next state, datapath and output decode.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    rx_ready_d  = 1'b0;
    bus_oe_n_d  = 1'b1;
    cs_n_d      = 1'b1;
    we_n_d      = 1'b1;
    cpu_rst_n_d = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;

    case (state_q)
      ST_ADDR_H: begin
        if (xfer) begin
          wr_d.addr[15:8] = bus.rxData;
          state_d         = ST_ADDR_L;
        end
      end
      ST_ADDR_L: begin
        if (xfer) begin
          wr_d.addr[7:0] = bus.rxData;
          state_d        = ST_CNT_H;
        end
      end
      ST_CNT_H: begin
        if (xfer) begin
          cnt_d[15:8] = bus.rxData;
          state_d     = ST_CNT_L;
        end
      end
      ST_CNT_L: begin
        if (xfer) begin
          cnt_d[7:0] = bus.rxData;
          state_d    = ({cnt_q[15:8], bus.rxData} != '0) ? ST_DATA_H : ST_CHK;
        end
      end
      ST_DATA_H: begin
        if (xfer) begin
          wr_d.data[15:8] = bus.rxData;
          state_d         = ST_DATA_L;
        end
      end
      ST_DATA_L: begin
        if (xfer) begin
          wr_d.data[7:0] = bus.rxData;
          state_d        = ST_W_SETUP;
        end
      end
      ST_W_SETUP: state_d = ST_W_PULSE;
      ST_W_PULSE: state_d = ST_W_HOLD;
      ST_W_HOLD: begin
        // Address wraps naturally at 16 bits.
        wr_d.addr = ADDR_W'(wr_q.addr + ADDR_W'(1));
        cnt_d     = CNT_W'(cnt_q - CNT_W'(1));
        state_d   = (cnt_q != CNT_W'(1)) ? ST_DATA_H : ST_CHK;
      end
      ST_CHK: begin
        if (xfer) begin
          state_d = (bus.rxData == sum) ? ST_DONE : ST_ERR;
        end
      end
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ADDR_H;
    endcase

    // Outputs are registered from the next state so they align with state_q.
    rx_ready_d  = is_rx_state(state_d);
    bus_oe_n_d  = !is_wr_state(state_d);
    cs_n_d      = !is_wr_state(state_d);
    we_n_d      = (state_d != ST_W_PULSE);
    cpu_rst_n_d = (state_d == ST_DONE);
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERR);
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state_q     <= ST_ADDR_H;
      wr_q        <= '0;
      cnt_q       <= '0;
      rx_ready_q  <= 1'b1;
      bus_oe_n_q  <= 1'b1;
      cs_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      rx_ready_q  <= rx_ready_d;
      bus_oe_n_q  <= bus_oe_n_d;
      cs_n_q      <= cs_n_d;
      we_n_q      <= we_n_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.rxReady     = rx_ready_q;
  assign bus.addrOut     = wr_q.addr;
  assign bus.dataOut     = wr_q.data;
  assign bus.notBusOE    = bus_oe_n_q;
  assign bus.memNotCS    = cs_n_q;
  assign bus.memNotWE    = we_n_q;
  assign bus.memNotOE    = 1'b1;
  assign bus.cpuNotReset = cpu_rst_n_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: table of known images, stall and
// mid-write reset sequences, and random images against a stream-level model.
`timescale 1ns/1ps
module tb_mem_loader;
  import mem_loader_pkg::*;

  typedef logic [7:0] bq_t[$];

  typedef struct packed {
    logic [4:0]       len;
    logic [15:0][7:0] b;
    logic [1:0]       gap;
    logic [1:0]       extra;
    logic             exp_done;
    logic             exp_err;
    logic [3:0]       exp_nwr;
    logic [15:0]      exp_a0;
    logic [15:0]      exp_d0;
  } vec_t;

  logic clock;
  logic notReset;
  mem_loader_if bus();

  mem_loader dut (
    .clock    (clock),
    .notReset (notReset),
    .bus      (bus)
  );

  int unsigned checks   = 0;
  int unsigned fails    = 0;
  int unsigned prot_err = 0;
  int unsigned cyc      = 0;

  logic [31:0] wr_log[$];
  logic [31:0] exp_log[$];
  logic        exp_done;
  logic        exp_err;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Bus-protocol watcher: strobe shape, bus stability, and SRAM write capture.
  int unsigned run    = 0;
  int unsigned we_cnt = 0;
  logic [15:0] run_addr;
  logic [15:0] run_data;
  always @(negedge clock) begin
    if (!notReset) begin
      run    = 0;
      we_cnt = 0;
    end else begin
      if (bus.memNotOE !== 1'b1) prot_err++;
      if (bus.notBusOE !== bus.memNotCS) prot_err++;
      if (bus.cpuNotReset !== bus.done) prot_err++;
      if (bus.memNotCS === 1'b0) begin
        if (bus.rxReady !== 1'b0) prot_err++;
        if (run == 0) begin
          run_addr = bus.addrOut;
          run_data = bus.dataOut;
        end else if (run_addr !== bus.addrOut || run_data !== bus.dataOut) begin
          prot_err++;
        end
        run++;
        if (bus.memNotWE === 1'b0) begin
          we_cnt++;
          wr_log.push_back({bus.addrOut, bus.dataOut});
        end
      end else begin
        if (bus.memNotWE !== 1'b1) prot_err++;
        if (run != 0) begin
          if (run != WRITE_PHASES || we_cnt != 1) prot_err++;
          run    = 0;
          we_cnt = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: parse the image and list the SRAM writes and final verdict.
  function automatic void model(input bq_t s);
    int unsigned base;
    int unsigned n;
    int unsigned sum;
    exp_log.delete();
    base = 32'({s[0], s[1]});
    n    = 32'({s[2], s[3]});
    sum  = 0;
    for (int unsigned i = 0; i < 4 + 2 * n; i++) sum += 32'(s[i]);
    for (int unsigned i = 0; i < n; i++)
      exp_log.push_back({16'((base + i) % 65536), s[4 + 2 * i], s[5 + 2 * i]});
    exp_done = (s[4 + 2 * n] == 8'(sum % 256));
    exp_err  = !exp_done;
  endfunction

  function automatic vec_t mk(input int unsigned len, input logic [127:0] bytes,
                              input logic [1:0] gap, input logic [1:0] extra,
                              input logic d, input logic e, input logic [3:0] nwr,
                              input logic [15:0] a0, input logic [15:0] d0);
    vec_t v;
    v = '0;
    v.len = 5'(len);
    for (int unsigned i = 0; i < len; i++) v.b[i] = bytes[(len - 1 - i) * 8 +: 8];
    v.gap = gap; v.extra = extra; v.exp_done = d; v.exp_err = e;
    v.exp_nwr = nwr; v.exp_a0 = a0; v.exp_d0 = d0;
    return v;
  endfunction

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (bus.rxReady === 1'b1) begin
        @(negedge clock);
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    bus.rxValid = 1'b0;
  endtask

  task automatic send_list(input bq_t s, input string tag);
    bit ok;
    for (int unsigned i = 0; i < s.size(); i++) begin
      bus.rxValid = 1'b1;
      bus.rxData  = s[i];
      wait_accept(ok);
      if (!ok) begin
        check({tag, "_accept"}, 32'(ok), 32'd1);
        return;
      end
    end
  endtask

  task automatic do_reset(input bit chk);
    bus.rxValid = 1'b0;
    bus.rxData  = '0;
    @(negedge clock);
    notReset = 1'b0;
    #1;
    if (chk) begin
      check("rst_rxReady",     32'(bus.rxReady),     32'd1);
      check("rst_addrOut",     32'(bus.addrOut),     32'd0);
      check("rst_dataOut",     32'(bus.dataOut),     32'd0);
      check("rst_notBusOE",    32'(bus.notBusOE),    32'd1);
      check("rst_memNotCS",    32'(bus.memNotCS),    32'd1);
      check("rst_memNotWE",    32'(bus.memNotWE),    32'd1);
      check("rst_memNotOE",    32'(bus.memNotOE),    32'd1);
      check("rst_cpuNotReset", 32'(bus.cpuNotReset), 32'd0);
      check("rst_done",        32'(bus.done),        32'd0);
      check("rst_error",       32'(bus.error),       32'd0);
    end
    @(negedge clock);
    @(negedge clock);
    notReset = 1'b1;
    wr_log.delete();
    prot_err = 0;
  endtask

  task automatic run_stream(input bq_t s, input int unsigned max_gap,
                            input int unsigned extra, input string tag);
    bit ok;
    int unsigned c0;
    int unsigned g;
    int unsigned nw;
    model(s);
    nw = exp_log.size();
    c0 = 0;
    for (int unsigned i = 0; i < s.size(); i++) begin
      g = (max_gap == 0) ? 0 : $urandom_range(0, max_gap);
      repeat (g) begin
        bus.rxValid = 1'b0;
        bus.rxData  = 8'($urandom);
        @(negedge clock);
      end
      bus.rxValid = 1'b1;
      bus.rxData  = s[i];
      if (i == 0) c0 = cyc;
      if (i == s.size() - 1) check({tag, "_cpurst_pre"}, 32'(bus.cpuNotReset), 32'd0);
      wait_accept(ok);
      if (!ok) begin
        check({tag, "_accept"}, 32'(ok), 32'd1);
        return;
      end
    end
    check({tag, "_cpurst_post"}, 32'(bus.cpuNotReset), 32'(exp_done));
    if (max_gap == 0) check({tag, "_cycles"}, cyc - c0, 5 + 5 * nw);
    // Bytes offered after the verdict must be ignored.
    repeat (extra) begin
      bus.rxValid = 1'b1;
      bus.rxData  = 8'($urandom);
      @(negedge clock);
    end
    bus.rxValid = 1'b0;
    repeat (4) @(negedge clock);
    check({tag, "_nwr"}, wr_log.size(), nw);
    for (int unsigned i = 0; i < nw && i < wr_log.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_log[i]);
    check({tag, "_done"},     32'(bus.done),        32'(exp_done));
    check({tag, "_error"},    32'(bus.error),       32'(exp_err));
    check({tag, "_cpurst"},   32'(bus.cpuNotReset), 32'(exp_done));
    check({tag, "_rxReady"},  32'(bus.rxReady),     32'd0);
    check({tag, "_protocol"}, prot_err,             32'd0);
  endtask

  initial begin
    vec_t        vecs[5];
    bq_t         s;
    bit          found;
    int unsigned a;
    int unsigned n;
    logic [7:0]  sum;

    notReset    = 1'b1;
    bus.rxValid = 1'b0;
    bus.rxData  = '0;

    // Full-stream sum of 00 10 00 02 12 34 AB CD is 0xD0; 0x12 is only the
    // header sum, so the second image must be rejected after writing.
    vecs[0] = mk(9, 128'h00100002_1234ABCD_D0, 2'd0, 2'd0, 1'b1, 1'b0, 4'd2, 16'h0010, 16'h1234);
    vecs[1] = mk(9, 128'h00100002_1234ABCD_12, 2'd1, 2'd0, 1'b0, 1'b1, 4'd2, 16'h0010, 16'h1234);
    vecs[2] = mk(9, 128'hFFFF0002_00010002_03, 2'd2, 2'd0, 1'b1, 1'b0, 4'd2, 16'hFFFF, 16'h0001);
    vecs[3] = mk(5, 128'h00000000_00,          2'd0, 2'd1, 1'b1, 1'b0, 4'd0, 16'h0000, 16'h0000);
    vecs[4] = mk(7, 128'h00100001_1234_00,     2'd0, 2'd3, 1'b0, 1'b1, 4'd1, 16'h0010, 16'h1234);

    for (int i = 0; i < 5; i++) begin
      do_reset(i == 0);
      s.delete();
      for (int unsigned j = 0; j < 32'(vecs[i].len); j++) s.push_back(vecs[i].b[j]);
      run_stream(s, 32'(vecs[i].gap), 32'(vecs[i].extra), $sformatf("vec%0d", i));
      check($sformatf("vec%0d_tbl_done", i),  32'(bus.done),  32'(vecs[i].exp_done));
      check($sformatf("vec%0d_tbl_error", i), 32'(bus.error), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_tbl_nwr", i),   wr_log.size(),  32'(vecs[i].exp_nwr));
      if (vecs[i].exp_nwr != 0 && wr_log.size() != 0)
        check($sformatf("vec%0d_tbl_wr0", i), wr_log[0], {vecs[i].exp_a0, vecs[i].exp_d0});
    end
    if (wr_log.size() == 1) check("vec4_wr_addr", 32'(wr_log[0][31:16]), 32'h0010);

    // Long idle mid-image: the loader waits with no timeout.
    do_reset(1'b0);
    send_list({8'h00, 8'h10, 8'h00, 8'h01, 8'h12}, "stall");
    repeat (40) begin
      bus.rxValid = 1'b0;
      bus.rxData  = 8'($urandom);
      @(negedge clock);
    end
    check("stall_rxReady", 32'(bus.rxReady),  32'd1);
    check("stall_cs",      32'(bus.memNotCS), 32'd1);
    check("stall_nwr",     wr_log.size(),     32'd0);
    send_list({8'h34, 8'h57}, "stall_tail");
    repeat (4) @(negedge clock);
    check("stall_done", 32'(bus.done), 32'd1);
    check("stall_nwr_end", wr_log.size(), 32'd1);
    if (wr_log.size() != 0) check("stall_wr0", wr_log[0], 32'h0010_1234);

    // Reset during the write strobe, then a fresh image.
    do_reset(1'b0);
    send_list({8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34}, "rstmid");
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (bus.memNotWE === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check("rstmid_we_seen", 32'(found), 32'd1);
    notReset = 1'b0;
    #1;
    check("rstmid_memNotWE", 32'(bus.memNotWE), 32'd1);
    check("rstmid_memNotCS", 32'(bus.memNotCS), 32'd1);
    check("rstmid_rxReady",  32'(bus.rxReady),  32'd1);
    check("rstmid_addrOut",  32'(bus.addrOut),  32'd0);
    check("rstmid_cpurst",   32'(bus.cpuNotReset), 32'd0);
    @(negedge clock);
    notReset = 1'b1;
    wr_log.delete();
    prot_err = 0;
    s = {8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hD0};
    run_stream(s, 0, 0, "rstmid_fresh");

    // Random images, some near the address wrap, some with bad checksums.
    for (int t = 0; t < 30; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF - $urandom_range(0, 3) : $urandom_range(0, 65535);
      n = $urandom_range(0, 6);
      s.delete();
      s.push_back(8'(a >> 8));
      s.push_back(8'(a));
      s.push_back(8'(n >> 8));
      s.push_back(8'(n));
      for (int unsigned j = 0; j < 2 * n; j++) s.push_back(8'($urandom));
      sum = 8'd0;
      foreach (s[j]) sum = 8'(sum + s[j]);
      if ($urandom_range(0, 3) == 0) sum = 8'(sum + 8'($urandom_range(1, 255)));
      s.push_back(sum);
      do_reset(1'b0);
      run_stream(s, $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
